// File: rtl/rf_write_arbiter_pkg.sv
// Shared types and default widths for the register-file write-port arbiter.
package rf_arb_pkg;

  localparam int RF_DATA_W       = 32;
  localparam int RF_ADDR_W       = 5;
  localparam int RF_BUF_DEPTH    = 2;
  localparam int RF_STARVE_LIMIT = 4;

  // One buffered long-latency result; live=0 means it pops without writing.
  typedef struct packed {
    logic [RF_ADDR_W-1:0] rd;
    logic [RF_DATA_W-1:0] data;
    logic                 live;
  } rf_entry_t;

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Bus bundle between the pipeline (writeback, long-latency unit, hazard unit)
// and the register-file write-port arbiter.
interface rf_write_arbiter_if
  import rf_arb_pkg::*;
#(
  parameter int DATA_WIDTH = RF_DATA_W,
  parameter int ADDR_WIDTH = RF_ADDR_W,
  parameter int BUF_DEPTH  = RF_BUF_DEPTH
);
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  logic                  wb_we;
  logic [ADDR_WIDTH-1:0] wb_rd;
  logic [DATA_WIDTH-1:0] wb_result;
  logic                  lu_valid;
  logic                  lu_ready;
  logic [ADDR_WIDTH-1:0] lu_rd;
  logic [DATA_WIDTH-1:0] lu_result;
  logic                  rf_we;
  logic [ADDR_WIDTH-1:0] rf_a3;
  logic [DATA_WIDTH-1:0] rf_wd3;
  logic                  wb_stall;
  logic [CNT_W-1:0]      buf_count;

  modport master (
    output wb_we, wb_rd, wb_result, lu_valid, lu_rd, lu_result,
    input  lu_ready, rf_we, rf_a3, rf_wd3, wb_stall, buf_count
  );

  modport slave (
    input  wb_we, wb_rd, wb_result, lu_valid, lu_rd, lu_result,
    output lu_ready, rf_we, rf_a3, rf_wd3, wb_stall, buf_count
  );

endinterface

// File: rtl/rf_write_arbiter_fifo.sv
// Circular buffer of long-latency results with an rd-match squash that marks
// matching stored entries dead when a younger writeback hits the same register.
module rf_wb_fifo
  import rf_arb_pkg::*;
#(
  parameter int DEPTH = RF_BUF_DEPTH,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  rf_entry_t            push_entry,
  input  logic                 pop,
  input  logic                 kill,
  input  logic [RF_ADDR_W-1:0] kill_rd,
  output rf_entry_t            head,
  output logic                 head_valid,
  output logic [CNT_W-1:0]     count
);

  rf_entry_t        mem_q [DEPTH];
  rf_entry_t        mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  // Next-state: squash matching entries, store the push, advance pointers.
  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (kill && (mem_q[i].rd == kill_rd)) mem_d[i].live = 1'b0;
    end
    if (push) mem_d[wr_ptr_q] = push_entry;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state: pointers and occupancy, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are meaningless while count is zero, so no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head       = mem_q[rd_ptr_q];
  assign head_valid = (count_q != '0);
  assign count      = count_q;

endmodule

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: writeback always wins, long-latency
// results drain from a small FIFO into idle port cycles, and a starvation
// counter asks the hazard unit for a writeback bubble.
// Entry field widths come from rf_arb_pkg; DATA_WIDTH/ADDR_WIDTH must match.
module rf_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int DATA_WIDTH   = RF_DATA_W,
  parameter int ADDR_WIDTH   = RF_ADDR_W,
  parameter int BUF_DEPTH    = RF_BUF_DEPTH,
  parameter int STARVE_LIMIT = RF_STARVE_LIMIT
) (
  input logic              clk,
  input logic              reset,
  rf_write_arbiter_if.slave bus
);

  localparam int CNT_W    = $clog2(BUF_DEPTH + 1);
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

  logic                  wb_write;
  logic                  head_valid;
  logic                  head_live;
  logic                  pop;
  logic                  push;
  logic                  lu_ready_c;
  rf_entry_t             head;
  rf_entry_t             push_entry;
  logic [CNT_W-1:0]      count;
  logic                  rf_we_c;
  logic [ADDR_WIDTH-1:0] rf_a3_c;
  logic [DATA_WIDTH-1:0] rf_wd3_c;
  logic [STARVE_W-1:0]   starve_cnt_q, starve_cnt_d;
  logic                  wb_stall_q, wb_stall_d;

  // Saturating increment so the counter parks at the limit while blocked.
  function automatic logic [STARVE_W-1:0] sat_inc(input logic [STARVE_W-1:0] v);
    if (v == STARVE_W'(STARVE_LIMIT)) return v;
    return v + STARVE_W'(1);
  endfunction

  // Port arbitration, FIFO push/pop decisions and squash of same-rd results.
  always_comb begin
    wb_write   = !reset && bus.wb_we && (bus.wb_rd != '0);
    head_live  = head_valid && head.live;
    pop        = !reset && head_valid && (!head.live || !wb_write);
    lu_ready_c = !reset && (count < CNT_W'(BUF_DEPTH));
    push       = bus.lu_valid && lu_ready_c;

    push_entry.rd   = bus.lu_rd;
    push_entry.data = bus.lu_result;
    push_entry.live = (bus.lu_rd != '0) && !(wb_write && (bus.wb_rd == bus.lu_rd));

    rf_we_c  = wb_write || (pop && head.live);
    rf_a3_c  = wb_write ? bus.wb_rd     : head.rd;
    rf_wd3_c = wb_write ? bus.wb_result : head.data;
  end

  // Starvation tracking and the sticky bubble request it produces.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (pop) starve_cnt_d = '0;
    else if (head_live && wb_write) starve_cnt_d = sat_inc(starve_cnt_q);
    wb_stall_d = pop ? 1'b0
                     : (wb_stall_q || (starve_cnt_d == STARVE_W'(STARVE_LIMIT)));
  end

  // Registered starvation state.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt_q <= '0;
      wb_stall_q   <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      wb_stall_q   <= wb_stall_d;
    end
  end

  rf_wb_fifo #(
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .kill       (wb_write),
    .kill_rd    (bus.wb_rd),
    .head       (head),
    .head_valid (head_valid),
    .count      (count)
  );

  assign bus.lu_ready  = lu_ready_c;
  assign bus.rf_we     = rf_we_c;
  assign bus.rf_a3     = rf_a3_c;
  assign bus.rf_wd3    = rf_wd3_c;
  assign bus.wb_stall  = wb_stall_q;
  assign bus.buf_count = count;

endmodule
